muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised, multi-cycle multiply/divide unit that owns the HI/LO register pair for the MIPS-lite core.
- Successor to the single-cycle combinational HI/LO path inside the ALU.
- Runs iterative shift-add multiply and restoring divide, signed and unsigned, behind a start/busy/done handshake.
- Sits beside the ALU in EX. Read ports feed MFHI/MFLO. The pipeline stalls on busy.

Parameters:
- WIDTH, 32: operand width and HI/LO width in bits; legal range 8 to 64, even.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=reserved (no-op)
- src_a  input  WIDTH  multiplicand / dividend / MTHI-MTLO data
- src_b  input  WIDTH  multiplier / divisor
- cancel  input  1  pipeline flush; aborts an in-flight operation
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO have been updated
- div_zero  output  1  sticky: last DIV/DIVU had divisor 0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; counter and datapath registers cleared.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE with start=1 and op 0/1:
  - Latch the magnitudes of src_a and src_b. For MULTU, and for MULT when the operand is non-negative, the magnitude is the raw value.
  - Latch result sign = sign(a) XOR sign(b) for signed ops only.
  - Go to MUL. busy=1 from the next cycle.
- IDLE with start=1 and op 2/3: same latching, but the remainder sign = sign(a). Go to DIV.
- IDLE with start=1 and op 4/5:
  - Write src_a to hi (op 4) or lo (op 5) at that edge; the other register is unchanged.
  - done=1 the following cycle. busy never asserts.
- IDLE with start=1 and op 6/7: ignored; no done, no state change.
- MUL: one partial-product add/shift per cycle for WIDTH cycles, then FIX.
- DIV: one restoring subtract/shift per cycle for WIDTH cycles, then FIX.
- FIX (one cycle):
  - Apply two's-complement correction to the product, or to the quotient and remainder.
  - Write hi and lo at the exit edge; done=1 and busy=0 in the next cycle. Return to IDLE.
- Latency start-to-done: WIDTH+2 cycles for MUL/DIV; 1 cycle for MTHI/MTLO.
- Results:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH product.
  - DIV/DIVU: lo = quotient (truncated toward zero), hi = remainder (sign of the dividend).
- Divide by zero:
  - Detected at acceptance. Go directly to FIX.
  - hi = src_a, lo = all ones. div_zero=1, held until the next accepted DIV/DIVU with a nonzero divisor.
  - Latency is 2 cycles.
- Signed overflow (DIV of most-negative by -1): lo = most-negative, hi = 0. No flag.
- start while busy=1: ignored. The caller must hold and retry.
- cancel=1 while busy:
  - Return to IDLE on the next edge. hi/lo unchanged; no done pulse.
  - A start in the same cycle as cancel is ignored.
- cancel=1 in IDLE: no effect. A simultaneous start is not accepted.
- Asserting rst mid-operation forces the reset values immediately.
- hi/lo change only at FIX exit or on MTHI/MTLO. Reads are always the registered values; there is no forwarding inside this block.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU compute the product with a single combinational multiplier registered at acceptance. MUL is skipped and the unit goes straight to FIX.
  - Multiply latency is 2 cycles. Divide is unchanged.
- Not defined: the iterative multiplier is used, with latency WIDTH+2.
- Results and hi/lo values are identical in both builds.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF (WIDTH=32) -> done at cycle 34; hi=0xFFFFFFFE, lo=0x00000001; busy high for cycles 1..33.
- MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=0x1234, b=0 -> done after 2 cycles; hi=0x1234, lo=0xFFFFFFFF, div_zero=1. A following DIVU 9/3 -> div_zero=0, lo=3, hi=0.
- MTHI 0xAAAA0000 then MTLO 0x5555 on consecutive cycles -> hi=0xAAAA0000, lo=0x5555; done pulses in each of the next two cycles.
- Start MULTU, assert cancel at cycle 10 -> busy=0 at cycle 11, no done, hi/lo keep their old values. Repeat with rst mid-DIV -> all outputs 0 immediately.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/handshake bus and HI/LO read ports of the multiply/divide unit.
// Master drives start/op/operands/cancel; slave returns busy/done/div_zero/hi/lo.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, cancel,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, cancel,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and restoring divide owning HI/LO; MULDIV_FAST_MUL_EN selects a one-shot multiplier.
// Latency: WIDTH+2 cycles MUL/DIV, 2 cycles fast multiply or divide-by-zero, 1 cycle MTHI/MTLO.
// Backpressure: start is ignored while busy (caller holds and retries); cancel aborts with no done.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 q_neg_q, q_neg_d;
  logic                 r_neg_q, r_neg_d;
  logic                 is_div_q, is_div_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 div_zero_q, div_zero_d;

  logic                 signed_op, sign_a, sign_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // Odd opcodes are the unsigned variants.
  assign signed_op = ~bus.op[0];
  assign sign_a    = signed_op & bus.src_a[WIDTH-1];
  assign sign_b    = signed_op & bus.src_b[WIDTH-1];
  assign mag_a     = sign_a ? -bus.src_a : bus.src_a;
  assign mag_b     = sign_b ? -bus.src_b : bus.src_b;

  // prod_q holds {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q & {WIDTH{prod_q[0]}}};
  assign div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

  assign prod_fix  = q_neg_q ? -prod_q : prod_q;
  assign quo_fix   = q_neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
  assign rem_fix   = r_neg_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opnd_d     = opnd_q;
    prod_d     = prod_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    is_div_d   = is_div_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.cancel) begin
          case (bus.op)
            3'd0, 3'd1: begin
              q_neg_d  = sign_a ^ sign_b;
              r_neg_d  = 1'b0;
              is_div_d = 1'b0;
              cnt_d    = '0;
`ifdef MULDIV_FAST_MUL_EN
              prod_d   = fast_prod;
              state_d  = S_FIX;
`else
              opnd_d   = mag_a;
              prod_d   = {{WIDTH{1'b0}}, mag_b};
              state_d  = S_MUL;
`endif
            end
            3'd2, 3'd3: begin
              is_div_d = 1'b1;
              cnt_d    = '0;
              if (bus.src_b == '0) begin
                // Preload the architectural divide-by-zero result; FIX passes it through uncorrected.
                div_zero_d = 1'b1;
                q_neg_d    = 1'b0;
                r_neg_d    = 1'b0;
                prod_d     = {bus.src_a, {WIDTH{1'b1}}};
                state_d    = S_FIX;
              end else begin
                div_zero_d = 1'b0;
                q_neg_d    = sign_a ^ sign_b;
                r_neg_d    = sign_a;
                opnd_d     = mag_b;
                prod_d     = {{WIDTH{1'b0}}, mag_a};
                state_d    = S_DIV;
              end
            end
            3'd4: begin
              hi_d   = bus.src_a;
              done_d = 1'b1;
            end
            3'd5: begin
              lo_d   = bus.src_a;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else begin
          prod_d = {mul_sum, prod_q[WIDTH-1:1]};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_d = S_FIX;
        end
      end
      S_DIV: begin
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else begin
          prod_d = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), prod_q[WIDTH-2:0], div_ge};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!bus.cancel) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      opnd_q     <= '0;
      prod_q     <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      is_div_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opnd_q     <= opnd_d;
      prod_q     <= prod_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      is_div_q   <= is_div_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus random operations against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_dz = 1'b0;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef MULDIV_FAST_MUL_EN
  localparam logic [2:0] CANCEL_OP = 3'd3;
`else
  localparam logic [2:0] CANCEL_OP = 3'd1;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic; SV / and % truncate toward zero with the dividend's sign.
  task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = 64'(sa * sb); {m_hi, m_lo} = p; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
      3'd2, 3'd3: begin
        if (b == '0) begin
          m_hi = a; m_lo = '1; m_dz = 1'b1;
        end else begin
          if (o == 3'd2) begin q = 64'(sa / sb); r = 64'(sa % sb); end
          else begin q = {32'b0, a / b}; r = {32'b0, a % b}; end
          m_lo = q[W-1:0]; m_hi = r[W-1:0]; m_dz = 1'b0;
        end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  function automatic int exp_lat(input logic [2:0] o, input logic [W-1:0] b);
    if (o >= 3'd4) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (o <= 3'd1) return 2;
`else
    if (o <= 3'd1) return W + 2;
`endif
    return (b == '0) ? 2 : W + 2;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit poke);
    int lat, cyc, busy_bad;
    lat = exp_lat(o, b);
    model(o, a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1; busy_bad = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (bus.busy !== 1'b1) busy_bad++;
      if (poke && cyc == 3) begin
        bus.start = 1'b1; bus.op = 3'd4; bus.src_a = 32'hDEAD_BEEF;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 64'(cyc), 64'(lat));
    check({tag, " busy_during"}, 64'(busy_bad), 64'(0));
    check({tag, " busy_at_done"}, 64'(bus.busy), 64'(1'b0));
    check({tag, " hi"}, 64'(bus.hi), 64'(m_hi));
    check({tag, " lo"}, 64'(bus.lo), 64'(m_lo));
    check({tag, " div_zero"}, 64'(bus.div_zero), 64'(m_dz));
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 64'(bus.done), 64'(1'b0));
  endtask

  initial begin
    logic [2:0]   o;
    logic [W-1:0] a, b;
    int           seen;

    bus.start = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0; bus.cancel = 1'b0;
    #2 rst = 1'b1;
    #10;
    check("rst busy", 64'(bus.busy), 64'(1'b0));
    check("rst done", 64'(bus.done), 64'(1'b0));
    check("rst div_zero", 64'(bus.div_zero), 64'(1'b0));
    check("rst hi", 64'(bus.hi), 64'(0));
    check("rst lo", 64'(bus.lo), 64'(0));
    @(negedge clk); rst = 1'b0;

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max hi_const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_max lo_const", 64'(bus.lo), 64'h0000_0000_0000_0001);
    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_neg lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFEB);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
    check("div_neg hi_const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 1'b1);
    check("divu_100_7 lo_const", 64'(bus.lo), 64'd14);
    run_op("divu_zero", 3'd3, 32'h0000_1234, 32'd0, 1'b0);
    check("divu_zero dz_const", 64'(bus.div_zero), 64'd1);
    run_op("divu_9_3", 3'd3, 32'd9, 32'd3, 1'b0);
    check("divu_9_3 dz_const", 64'(bus.div_zero), 64'd0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf lo_const", 64'(bus.lo), 64'h0000_0000_8000_0000);

    // Back-to-back MTHI then MTLO.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd4; bus.src_a = 32'hAAAA_0000;
    @(posedge clk); #1;
    check("mthi done", 64'(bus.done), 64'(1'b1));
    check("mthi hi", 64'(bus.hi), 64'h0000_0000_AAAA_0000);
    @(negedge clk);
    bus.op = 3'd5; bus.src_a = 32'h0000_5555;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("mtlo done", 64'(bus.done), 64'(1'b1));
    check("mtlo lo", 64'(bus.lo), 64'h0000_0000_0000_5555);
    check("mtlo hi_kept", 64'(bus.hi), 64'h0000_0000_AAAA_0000);
    m_hi = 32'hAAAA_0000; m_lo = 32'h0000_5555;
    @(posedge clk); #1;
    check("mt done_end", 64'(bus.done), 64'(1'b0));

    // Reserved opcode: nothing happens.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd6; bus.src_a = 32'h1111_1111;
    @(posedge clk); #1;
    bus.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      @(posedge clk); #1;
    end
    check("reserved activity", 64'(seen), 64'(0));
    check("reserved hi", 64'(bus.hi), 64'(m_hi));

    // Cancel in IDLE blocks a simultaneous start.
    @(negedge clk);
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 3'd4; bus.src_a = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.cancel = 1'b0;
    check("idle_cancel done", 64'(bus.done), 64'(1'b0));
    check("idle_cancel hi", 64'(bus.hi), 64'(m_hi));

    // Cancel at cycle 10 of a long operation.
    @(negedge clk);
    bus.start = 1'b1; bus.op = CANCEL_OP; bus.src_a = 32'h1234_5678; bus.src_b = 32'h0000_0033;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.cancel = 1'b1; bus.start = 1'b1; bus.op = 3'd5; bus.src_a = 32'hFEED_FACE;
    @(posedge clk); #1;
    bus.cancel = 1'b0; bus.start = 1'b0;
    check("cancel busy", 64'(bus.busy), 64'(1'b0));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    check("cancel no_done", 64'(seen), 64'(0));
    check("cancel hi", 64'(bus.hi), 64'(m_hi));
    check("cancel lo", 64'(bus.lo), 64'(m_lo));

    // Random operations, including corner operands.
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'hFFFF_FFFF;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), o, a, b, (o == 3'd2 || o == 3'd3) && b != '0 && (i % 4 == 0));
    end

    // Reset in the middle of a divide clears everything immediately.
    run_op("pre_rst_dz", 3'd2, 32'h7777_0000, 32'd0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd2; bus.src_a = 32'hF000_0001; bus.src_b = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst busy", 64'(bus.busy), 64'(1'b0));
    check("midrst done", 64'(bus.done), 64'(1'b0));
    check("midrst div_zero", 64'(bus.div_zero), 64'(1'b0));
    check("midrst hi", 64'(bus.hi), 64'(0));
    check("midrst lo", 64'(bus.lo), 64'(0));
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
